ifu_mem_fill: RTL and testbench

Miss-fill engine between `ifu_cache` and the instruction memory port. It accepts line-miss tags from the cache's memory request side and queues them in a small FIFO. For each queued tag it issues word-sized read beats to memory and assembles the returned words into one cache line. The finished line and its tag go back to the cache's memory response inputs as a single-cycle valid pulse.

---
 rtl/ifu_mem_fill.sv | 173 +++++++++++++++++
 tb/tb_ifu_mem_fill.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_mem_fill.sv
// ifu_mem_fill: miss-fill engine between ifu_cache and the instruction memory port.
// Queues miss tags, issues one read beat per word, assembles the line and returns it
// to the cache as a one-cycle pulse.
// Optional build macro IFU_FILL_DEDUP_EN: drop incoming tags already present in the queue.
module ifu_mem_fill #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 28,
  parameter int unsigned REQ_DEPTH  = 4
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
  input  logic                  cache_reqTagValidIn,
  output logic                  cache_reqReadyOut,
  output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
  output logic [LINE_WIDTH-1:0] cache_rspInsLineOut,
  output logic                  cache_rspInsLineValidOut,
  output logic [ADDR_WIDTH-1:0] mem_rdAddrOut,
  output logic                  mem_rdReqOut,
  input  logic                  mem_rdReadyIn,
  input  logic [WORD_WIDTH-1:0] mem_rdDataIn,
  input  logic                  mem_rdDataValidIn
);

  localparam int unsigned BEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned IDXW  = $clog2(BEATS);
  localparam int unsigned CNTW  = IDXW + 1;
  localparam int unsigned BYTEW = $clog2(WORD_WIDTH / 8);
  localparam int unsigned PTRW  = $clog2(REQ_DEPTH);
  localparam int unsigned QCW   = PTRW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [TAG_WIDTH-1:0]  head_tag_q, head_tag_d;
  logic [CNTW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0]       data_cnt_q, data_cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [LINE_WIDTH-1:0] rsp_line_q, rsp_line_d;

  logic [TAG_WIDTH-1:0]  q_mem [REQ_DEPTH];
  logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q, rd_next;
  logic [QCW-1:0]        count_q;

  logic push, pop, dup, accept, capture;

  assign cache_reqReadyOut        = (count_q != QCW'(REQ_DEPTH));
  assign mem_rdReqOut             = (state_q == S_ISSUE);
  assign cache_rspInsLineValidOut = (state_q == S_RESP);
  assign cache_rspTagOut          = rsp_tag_q;
  assign cache_rspInsLineOut      = rsp_line_q;
  assign mem_rdAddrOut            = {head_tag_q, issue_cnt_q[IDXW-1:0], {BYTEW{1'b0}}};

  assign push    = cache_reqTagValidIn && cache_reqReadyOut && !dup;
  assign pop     = (state_q == S_RESP);
  assign accept  = mem_rdReqOut && mem_rdReadyIn;
  assign capture = mem_rdDataValidIn && (state_q == S_ISSUE || state_q == S_COLLECT)
                   && (data_cnt_q < issue_cnt_q);
  assign rd_next = rd_ptr_q + PTRW'(1);

`ifdef IFU_FILL_DEDUP_EN
  logic [PTRW-1:0] occ_off [REQ_DEPTH];

  // Flag an incoming tag that matches any occupied entry, head included.
  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < REQ_DEPTH; i++) begin
      occ_off[i] = PTRW'(i) - rd_ptr_q;
      if (({1'b0, occ_off[i]} < count_q) && (q_mem[i] == cache_reqTagIn)) dup = 1'b1;
    end
  end
`else
  // Every accepted tag is queued, duplicates included.
  always_comb dup = 1'b0;
`endif

  // Miss queue storage; occupancy is tracked by count_q, so entries need no reset.
  always_ff @(posedge Clock) begin
    if (push) q_mem[wr_ptr_q] <= cache_reqTagIn;
  end

  // Miss queue pointers and occupancy.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_next;
      if (push && !pop)      count_q <= count_q + QCW'(1);
      else if (pop && !push) count_q <= count_q - QCW'(1);
    end
  end

  // Fill FSM and datapath registers.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      head_tag_q  <= '0;
      issue_cnt_q <= '0;
      data_cnt_q  <= '0;
      line_q      <= '0;
      rsp_tag_q   <= '0;
      rsp_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_tag_q  <= head_tag_d;
      issue_cnt_q <= issue_cnt_d;
      data_cnt_q  <= data_cnt_d;
      line_q      <= line_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_line_q  <= rsp_line_d;
    end
  end

  // Next-state logic. A tag pushed into an empty queue is taken straight into the head
  // register, and COLLECT looks at the word arriving this cycle, so a fill with
  // single-cycle memory completes in six cycles.
  always_comb begin
    state_d     = state_q;
    head_tag_d  = head_tag_q;
    issue_cnt_d = issue_cnt_q;
    data_cnt_d  = data_cnt_q;
    line_d      = line_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_line_d  = rsp_line_q;

    if (capture) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (data_cnt_q[IDXW-1:0] == IDXW'(k)) line_d[k*WORD_WIDTH +: WORD_WIDTH] = mem_rdDataIn;
      end
      data_cnt_d = data_cnt_q + CNTW'(1);
    end
    if (accept) issue_cnt_d = issue_cnt_q + CNTW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0 || push) begin
          head_tag_d  = (count_q != '0) ? q_mem[rd_ptr_q] : cache_reqTagIn;
          issue_cnt_d = '0;
          data_cnt_d  = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept && issue_cnt_q == CNTW'(BEATS - 1)) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (data_cnt_d == CNTW'(BEATS)) begin
          rsp_tag_d  = head_tag_q;
          rsp_line_d = line_d;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (count_q > QCW'(1) || push) begin
          head_tag_d  = (count_q > QCW'(1)) ? q_mem[rd_next] : cache_reqTagIn;
          issue_cnt_d = '0;
          data_cnt_d  = '0;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu_mem_fill.sv
// Testbench for ifu_mem_fill: directed scenarios plus randomized traffic, checked against
// a tag-queue / memory-image reference model.
module tb_ifu_mem_fill;
  logic         Clock = 1'b0;
  logic         Rst;
  logic [27:0]  tag_in;
  logic         tag_v;
  logic         ready_o;
  logic [27:0]  rsp_tag;
  logic [127:0] rsp_line;
  logic         rsp_v;
  logic [31:0]  addr;
  logic         req;
  logic         mem_rdy;
  logic [31:0]  mem_data;
  logic         mem_dv;

  ifu_mem_fill #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .WORD_WIDTH(32), .TAG_WIDTH(28), .REQ_DEPTH(4)) dut (
    .Clock(Clock), .Rst(Rst),
    .cache_reqTagIn(tag_in), .cache_reqTagValidIn(tag_v), .cache_reqReadyOut(ready_o),
    .cache_rspTagOut(rsp_tag), .cache_rspInsLineOut(rsp_line), .cache_rspInsLineValidOut(rsp_v),
    .mem_rdAddrOut(addr), .mem_rdReqOut(req), .mem_rdReadyIn(mem_rdy),
    .mem_rdDataIn(mem_data), .mem_rdDataValidIn(mem_dv)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [31:0] a; int unsigned epoch; } beat_t;

  int unsigned total = 0, bad = 0;
  logic [27:0]  mq[$];
  beat_t        pend[$];
  logic [31:0]  preset [logic [31:0]];
  int unsigned  epoch = 0, beats = 0, words = 0, cyc = 0;
  int unsigned  dut_pulses = 0, dut_pulse_cyc = 0;
  logic [127:0] dut_line;
  logic [27:0]  last_tag;
  logic [127:0] last_line;
  bit rand_lat = 0, stray_now = 0, tag_acc = 0;

  task automatic tally(input bit ok, input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] memword(logic [31:0] a);
    if (preset.exists(a)) return preset[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [127:0] exp_line(logic [27:0] t);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = memword({t, 2'(k), 2'b00});
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    beats = 0; words = 0; epoch++;
    last_tag = '0; last_line = '0;
  endtask

  task automatic cycle();
    bit deliver, exp_ready, exp_pulse, beat_acc, is_dup, exp_req;
    beat_t b;
    logic [31:0] a_seen;
    logic [127:0] el;
    deliver = 0; mem_dv = 0; mem_data = '0;
    if (stray_now) begin
      mem_dv = 1; mem_data = 32'hBAD0BAD0;
    end else if (pend.size() != 0 && (!rand_lat || $urandom_range(0, 9) < 6)) begin
      b = pend.pop_front(); deliver = 1; mem_dv = 1; mem_data = memword(b.a);
    end
    stray_now = 0;
    #1;
    exp_ready = (mq.size() < 4);
    exp_pulse = (words == 4);
    exp_req   = (mq.size() != 0 && beats < 4);
    tally(ready_o === exp_ready, "ready", ready_o, exp_ready);
    tally(req === exp_req, "req", req, exp_req);
    if (req && mq.size() != 0)
      tally(addr === {mq[0], 2'(beats), 2'b00}, "addr", addr, {mq[0], 2'(beats), 2'b00});
    tally(rsp_v === exp_pulse, "pulse", rsp_v, exp_pulse);
    if (rsp_v && mq.size() != 0) begin
      el = exp_line(mq[0]);
      tally(rsp_tag === mq[0], "rsp_tag", rsp_tag, mq[0]);
      tally(rsp_line === el, "rsp_line", rsp_line, el);
    end else if (!rsp_v) begin
      tally(rsp_tag === last_tag, "hold_tag", rsp_tag, last_tag);
      tally(rsp_line === last_line, "hold_line", rsp_line, last_line);
    end
    if (rsp_v) begin dut_pulses++; dut_pulse_cyc = cyc; dut_line = rsp_line; end
    is_dup = 0;
`ifdef IFU_FILL_DEDUP_EN
    foreach (mq[i]) if (mq[i] == tag_in) is_dup = 1;
`endif
    beat_acc = req && mem_rdy;
    a_seen   = addr;
    tag_acc  = tag_v && exp_ready && !is_dup;
    @(posedge Clock);
    if (Rst) begin
      model_clear();
    end else begin
      if (beat_acc) begin pend.push_back('{a: a_seen, epoch: epoch}); beats++; end
      if (deliver && b.epoch == epoch) words++;
      if (exp_pulse && mq.size() != 0) begin
        last_tag = mq[0]; last_line = exp_line(mq[0]);
        void'(mq.pop_front()); beats = 0; words = 0;
      end
      if (tag_acc) mq.push_back(tag_in);
    end
    cyc++;
    @(negedge Clock);
  endtask

  task automatic wait_drain(input int unsigned max);
    int unsigned left;
    for (int unsigned i = 0; i < max && !(mq.size() == 0 && pend.size() == 0); i++) cycle();
    left = mq.size() + pend.size();
    tally(left == 0, "drain", left, 0);
  endtask

  task automatic push_one(input logic [27:0] t);
    tag_in = t; tag_v = 1; cycle(); tag_v = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, p0, stalls, exp_n;
    bit exp_rdy_dup, has_bad;
    logic [127:0] el4;
    Rst = 1; tag_in = '0; tag_v = 0; mem_rdy = 1; mem_dv = 0; mem_data = '0;
    last_tag = '0; last_line = '0; dut_line = '0;
    preset[32'h10] = 32'hDEADBEEF; preset[32'h14] = 32'h11111111;
    preset[32'h18] = 32'h22222222; preset[32'h1C] = 32'h33333333;

    @(negedge Clock);
    tally(ready_o === 1'b1, "rst_ready", ready_o, 1);
    tally(rsp_v === 1'b0, "rst_valid", rsp_v, 0);
    tally(req === 1'b0, "rst_req", req, 0);
    tally(addr === 32'h0, "rst_addr", addr, 0);
    tally(rsp_line === 128'h0, "rst_line", rsp_line, 0);
    cycle(); cycle();
    Rst = 0;
    cycle();

    c0 = cyc; push_one(28'h1);
    wait_drain(40);
    tally((dut_pulse_cyc - c0) == 6, "t1_latency", dut_pulse_cyc - c0, 6);
    tally(dut_line === 128'h33333333_22222222_11111111_DEADBEEF, "t1_line", dut_line,
          128'h33333333_22222222_11111111_DEADBEEF);

    c0 = cyc; push_one(28'h5); stalls = 0;
    for (int i = 0; i < 40 && !(mq.size() == 0 && pend.size() == 0); i++) begin
      if (beats == 2 && stalls < 3) begin mem_rdy = 0; stalls++; end
      else mem_rdy = 1;
      cycle();
    end
    mem_rdy = 1;
    tally((dut_pulse_cyc - c0) == 9, "t2_latency", dut_pulse_cyc - c0, 9);

    mem_rdy = 0; p0 = dut_pulses;
    for (int t = 1; t <= 4; t++) begin tag_in = 28'(t); tag_v = 1; cycle(); end
    tag_in = 28'h9;
    tally(ready_o === 1'b0, "t3_full", ready_o, 0);
    cycle(); cycle(); cycle();
    mem_rdy = 1;
    for (int i = 0; i < 60; i++) begin cycle(); if (tag_acc) break; end
    tag_v = 0;
    wait_drain(100);
    tally((dut_pulses - p0) == 5, "t3_pulses", dut_pulses - p0, 5);

    mem_rdy = 0; p0 = dut_pulses; tag_in = 28'h2; tag_v = 1;
    repeat (10) cycle();
    tag_v = 0;
`ifdef IFU_FILL_DEDUP_EN
    exp_rdy_dup = 1; exp_n = 1;
`else
    exp_rdy_dup = 0; exp_n = 4;
`endif
    tally(ready_o === exp_rdy_dup, "t4_ready", ready_o, exp_rdy_dup);
    mem_rdy = 1;
    wait_drain(100);
    tally((dut_pulses - p0) == exp_n, "t4_pulses", dut_pulses - p0, exp_n);

    push_one(28'h3);
    for (int i = 0; i < 10 && beats < 2; i++) cycle();
    Rst = 1; #1;
    tally(rsp_v === 1'b0, "t5_valid", rsp_v, 0);
    tally(req === 1'b0, "t5_req", req, 0);
    tally(ready_o === 1'b1, "t5_ready", ready_o, 1);
    tally(rsp_tag === 28'h0, "t5_tag", rsp_tag, 0);
    tally(rsp_line === 128'h0, "t5_line", rsp_line, 0);
    model_clear();
    cycle();
    Rst = 0;
    cycle(); cycle(); cycle();
    push_one(28'h4);
    wait_drain(40);
    el4 = exp_line(28'h4);
    tally(dut_line === el4, "t5_refill", dut_line, el4);

    stray_now = 1; cycle(); cycle();
    push_one(28'h6);
    wait_drain(40);
    has_bad = 0;
    for (int k = 0; k < 4; k++) if (dut_line[32*k +: 32] == 32'hBAD0BAD0) has_bad = 1;
    tally(has_bad == 1'b0, "t6_nostray", has_bad, 0);

    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      tag_v   = ($urandom_range(0, 9) < 3);
      tag_in  = 28'($urandom_range(0, 7));
      mem_rdy = ($urandom_range(0, 9) < 7);
      cycle();
    end
    tag_v = 0; mem_rdy = 1;
    wait_drain(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
